// File: rtl/vc_table_pkg.sv
// Shared types for the programmable VC lookup shim: table entry layout,
// packet-framing state and the miss counter ceiling.
package vc_table_pkg;

    localparam int TBL_N_ADDR_WIDTH  = 4;
    localparam int TBL_VC_ADDR_WIDTH = 2;

    localparam logic [15:0] MISS_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [TBL_N_ADDR_WIDTH-1:0]  dest;
        logic [TBL_VC_ADDR_WIDTH-1:0] vc;
        logic                         en;
    } vc_entry_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/vc_lookup_cam.sv
// Combinational priority match of a destination against the VC table;
// the lowest-index valid entry with a matching destination wins.
module vc_lookup_cam
    import vc_table_pkg::*;
#(
    parameter int N_ADDR_WIDTH  = TBL_N_ADDR_WIDTH,
    parameter int VC_ADDR_WIDTH = TBL_VC_ADDR_WIDTH,
    parameter int NUM_DEST      = 4
) (
    input  vc_entry_t                entries [NUM_DEST],
    input  logic [N_ADDR_WIDTH-1:0]  dest,
    output logic                     hit,
    output logic [VC_ADDR_WIDTH-1:0] vc
);

    logic [NUM_DEST-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_match
            assign match[gi] = entries[gi].en && (entries[gi].dest == dest);
        end
    endgenerate

    // Walk from the top down so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        vc  = '0;
        for (int k = NUM_DEST - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                vc  = entries[k].vc;
            end
        end
    end

endmodule

// File: rtl/vc_table_prog.sv
// Registered VC tagging shim: head flits look up their destination in a
// writable table, and the whole packet carries that VC through a 1-deep stage.
module vc_table_prog
    import vc_table_pkg::*;
#(
    parameter int N_ADDR_WIDTH  = TBL_N_ADDR_WIDTH,
    parameter int VC_ADDR_WIDTH = TBL_VC_ADDR_WIDTH,
    parameter int NUM_DEST      = 4,
    parameter int WIDTH         = 36,
    parameter logic [N_ADDR_WIDTH-1:0]  DEST [NUM_DEST] = '{default: N_ADDR_WIDTH'(1)},
    parameter logic [VC_ADDR_WIDTH-1:0] VC   [NUM_DEST] = '{default: VC_ADDR_WIDTH'(1)},
    parameter logic [VC_ADDR_WIDTH-1:0] DEFAULT_VC = '0,
    localparam int IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_wr_en,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [N_ADDR_WIDTH-1:0]  cfg_dest,
    input  logic [VC_ADDR_WIDTH-1:0] cfg_vc,
    input  logic                     cfg_en,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [N_ADDR_WIDTH-1:0]  i_dest,
    input  logic                     i_head,
    input  logic                     i_tail,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [VC_ADDR_WIDTH-1:0] o_vc,
    output logic                     o_head,
    output logic                     o_tail,
    output logic                     o_miss,
    output logic [15:0]              miss_count,
    output logic                     err
);

    vc_entry_t tbl_reg [NUM_DEST];

    pkt_state_t               state_reg;
    logic [VC_ADDR_WIDTH-1:0] held_vc_reg;
    logic                     held_miss_reg;
    logic                     o_valid_reg;
    logic [WIDTH-1:0]         o_data_reg;
    logic [VC_ADDR_WIDTH-1:0] o_vc_reg;
    logic                     o_head_reg;
    logic                     o_tail_reg;
    logic                     o_miss_reg;
    logic [15:0]              miss_count_reg;
    logic                     err_reg;

    logic                     cam_hit;
    logic [VC_ADDR_WIDTH-1:0] cam_vc;
    logic                     accept;
    logic [VC_ADDR_WIDTH-1:0] flit_vc_next;
    logic                     flit_miss_next;

    // Each entry only reacts to its own index, so out-of-range writes fall through.
    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tbl_reg[gi] <= '{dest: DEST[gi], vc: VC[gi], en: 1'b1};
                end else if (cfg_wr_en && (cfg_idx == IDX_W'(gi))) begin
                    tbl_reg[gi] <= '{dest: cfg_dest, vc: cfg_vc, en: cfg_en};
                end
            end
        end
    endgenerate

    vc_lookup_cam #(
        .N_ADDR_WIDTH  (N_ADDR_WIDTH),
        .VC_ADDR_WIDTH (VC_ADDR_WIDTH),
        .NUM_DEST      (NUM_DEST)
    ) u_cam (
        .entries (tbl_reg),
        .dest    (i_dest),
        .hit     (cam_hit),
        .vc      (cam_vc)
    );

    assign i_ready = !o_valid_reg || o_ready;
    assign accept  = i_valid && i_ready;

    always_comb begin
        flit_vc_next   = held_vc_reg;
        flit_miss_next = held_miss_reg;
        if (i_head) begin
            flit_vc_next   = cam_hit ? cam_vc : DEFAULT_VC;
            flit_miss_next = !cam_hit;
        end else if (state_reg == IDLE) begin
            // Orphan body/tail with no packet context.
            flit_vc_next   = DEFAULT_VC;
            flit_miss_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            held_vc_reg    <= DEFAULT_VC;
            held_miss_reg  <= 1'b0;
            o_valid_reg    <= 1'b0;
            o_data_reg     <= '0;
            o_vc_reg       <= '0;
            o_head_reg     <= 1'b0;
            o_tail_reg     <= 1'b0;
            o_miss_reg     <= 1'b0;
            miss_count_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                o_valid_reg <= 1'b1;
                o_data_reg  <= i_data;
                o_vc_reg    <= flit_vc_next;
                o_head_reg  <= i_head;
                o_tail_reg  <= i_tail;
                o_miss_reg  <= flit_miss_next;
                if (i_head) begin
                    if (state_reg == IN_PKT) begin
                        err_reg <= 1'b1;
                    end
                    if (!cam_hit && (miss_count_reg != MISS_CNT_MAX)) begin
                        miss_count_reg <= miss_count_reg + 16'd1;
                    end
                    if (i_tail) begin
                        state_reg <= IDLE;
                    end else begin
                        state_reg     <= IN_PKT;
                        held_vc_reg   <= flit_vc_next;
                        held_miss_reg <= flit_miss_next;
                    end
                end else if (state_reg == IDLE) begin
                    err_reg <= 1'b1;
                end else if (i_tail) begin
                    state_reg <= IDLE;
                end
            end else if (o_ready) begin
                o_valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid    = o_valid_reg;
    assign o_data     = o_data_reg;
    assign o_vc       = o_vc_reg;
    assign o_head     = o_head_reg;
    assign o_tail     = o_tail_reg;
    assign o_miss     = o_miss_reg;
    assign miss_count = miss_count_reg;
    assign err        = err_reg;

endmodule
